barcode_station_ctrl: RTL and testbench

BARCODE_STATION_CTRL -- requirements
Module: barcode_station_ctrl

---
 rtl/barcode_station_ctrl.sv | 135 +++++++++++++
 tb/tb_barcode_station_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/barcode_station_ctrl.sv
// Barcode-guided station positioning controller with a RUN-state watchdog.
// Optional macro STATION_MISS_LIMIT_EN: fault after MISS_LIMIT mismatched stations.
module barcode_station_ctrl #(
    parameter int unsigned      TMO_W      = 24,
    parameter logic [TMO_W-1:0] TMO_CYC    = 24'd10_000_000,
    parameter logic [3:0]       MISS_LIMIT = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_vld,
    input  logic [5:0] cmd_dest,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    output logic       go,
    output logic       arrived,
    output logic [5:0] station,
    output logic [3:0] pass_cnt,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_CHECK  = 3'd2,
        S_ARRIVE = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

    state_t           state_q, state_d;
    logic [5:0]       dest_q, dest_d;
    logic [5:0]       station_q, station_d;
    logic [3:0]       pass_q, pass_d;
    logic [TMO_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic [3:0]       pass_inc;
    logic             unused_bits;

    assign pass_inc = (pass_q == 4'hF) ? pass_q : pass_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        station_d = station_q;
        pass_d    = pass_q;
        wd_d      = wd_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_FAULT: begin
                if (cmd_vld) begin
                    dest_d  = cmd_dest;
                    pass_d  = 4'd0;
                    wd_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A new command wins; any pending ID is evaluated next cycle against it.
                if (cmd_vld) begin
                    dest_d = cmd_dest;
                    pass_d = 4'd0;
                    wd_d   = '0;
                end else if (ID_vld) begin
                    station_d = ID[5:0];
                    wd_d      = wd_q + 1'b1;
                    state_d   = S_CHECK;
                end else if (wd_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (station_q == dest_q) begin
                    state_d = S_ARRIVE;
                end else begin
                    pass_d  = pass_inc;
                    wd_d    = '0;
`ifdef STATION_MISS_LIMIT_EN
                    if (pass_inc == MISS_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_ARRIVE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dest_q    <= '0;
            station_q <= '0;
            pass_q    <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            station_q <= station_d;
            pass_q    <= pass_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
        end
    end

    // Stale reads are flushed whenever the block is not tracking motion.
    assign clr_ID_vld = (state_q == S_IDLE || state_q == S_FAULT) ? ID_vld
                                                                 : (state_q == S_CHECK);
    assign go         = (state_q == S_RUN) || (state_q == S_CHECK);
    assign busy       = (state_q == S_RUN) || (state_q == S_CHECK) || (state_q == S_ARRIVE);
    assign arrived    = (state_q == S_ARRIVE);
    assign station    = station_q;
    assign pass_cnt   = pass_q;
    assign err        = err_q;

`ifdef STATION_MISS_LIMIT_EN
    assign unused_bits = ^ID[7:6];
`else
    assign unused_bits = ^{ID[7:6], MISS_LIMIT};
`endif

endmodule

// File: tb/tb_barcode_station_ctrl.sv
// Directed plus randomized bench for barcode_station_ctrl, with a reader model and expected-count tracking.
module tb_barcode_station_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_vld;
    logic [5:0] cmd_dest;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld, go, arrived, err, busy;
    logic [5:0] station;
    logic [3:0] pass_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [3:0] MLIM = 4'd2;
`ifdef STATION_MISS_LIMIT_EN
    localparam int MAX_MISS = 1;
`else
    localparam int MAX_MISS = 4;
`endif

    logic [5:0] exp_station = 6'd0;

    always #5 clk = ~clk;

    barcode_station_ctrl #(
        .TMO_W     (24),
        .TMO_CYC   (24'd100),
        .MISS_LIMIT(MLIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_vld   (cmd_vld),
        .cmd_dest  (cmd_dest),
        .ID        (ID),
        .ID_vld    (ID_vld),
        .clr_ID_vld(clr_ID_vld),
        .go        (go),
        .arrived   (arrived),
        .station   (station),
        .pass_cnt  (pass_cnt),
        .err       (err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [5:0] d);
        cmd_dest = d;
        cmd_vld  = 1'b1;
        step();
        cmd_vld  = 1'b0;
    endtask

    // Reader presents an ID; it drops ID_vld on the edge where clr_ID_vld was seen.
    task automatic send_id(input logic [7:0] id);
        ID     = id;
        ID_vld = 1'b1;
        step();
        chk("clr_in_check", clr_ID_vld, 1);
        chk("go_in_check", go, 1);
        chk("station_capture", station, id[5:0]);
        exp_station = id[5:0];
        step();
        ID_vld = 1'b0;
    endtask

    initial begin
        logic [5:0] d;
        logic [7:0] id;
        int         nmiss, gap, exp_pass;
        logic       go_held;

        rst = 1'b1; cmd_vld = 1'b0; cmd_dest = '0; ID = '0; ID_vld = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_go", go, 0);
        chk("rst_arrived", arrived, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_station", station, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_clr", clr_ID_vld, 0);

        // Stale ID in IDLE is flushed immediately and not captured
        ID = 8'h2A; ID_vld = 1'b1; #1;
        chk("idle_clr_follow", clr_ID_vld, 1);
        step();
        chk("idle_station_kept", station, 0);
        chk("idle_busy", busy, 0);
        ID_vld = 1'b0; #1;
        chk("idle_clr_low", clr_ID_vld, 0);

        // Basic arrival
        start(6'h05);
        chk("cmd_go", go, 1);
        chk("cmd_busy", busy, 1);
        send_id(8'h05);
        chk("arr_pulse", arrived, 1);
        chk("arr_go", go, 0);
        chk("arr_station", station, 5);
        cmd_dest = 6'h01; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        chk("arrive_ignores_cmd", busy, 0);
        chk("arr_done", arrived, 0);

        // Passing stations before the destination
        start(6'h07);
        send_id(8'h01);
        chk("pass1", pass_cnt, 1);
        chk("pass1_noarr", arrived, 0);
        send_id(8'h02);
        chk("pass2", pass_cnt, 2);
`ifdef STATION_MISS_LIMIT_EN
        chk("miss_fault_err", err, 1);
        chk("miss_fault_go", go, 0);
        chk("miss_fault_busy", busy, 0);
`else
        chk("pass2_go", go, 1);
        send_id(8'h07);
        chk("pass_arrive", arrived, 1);
        chk("pass_arrive_cnt", pass_cnt, 2);
        step();
`endif

        // Watchdog: fault exactly 100 cycles after go rises
        start(6'h03);
        chk("tmo_go", go, 1);
        chk("tmo_err_cleared", err, 0);
        go_held = 1'b1;
        for (int i = 1; i < 100; i++) begin
            step();
            if (go !== 1'b1) go_held = 1'b0;
        end
        chk("tmo_go_held", go_held, 1);
        step();
        chk("tmo_err", err, 1);
        chk("tmo_go_off", go, 0);
        chk("tmo_busy", busy, 0);
        ID = 8'h12; ID_vld = 1'b1; #1;
        chk("fault_clr_follow", clr_ID_vld, 1);
        step();
        chk("fault_station_kept", station, exp_station);
        ID_vld = 1'b0;
        start(6'h11);
        chk("recover_err", err, 0);
        chk("recover_go", go, 1);

        // Simultaneous command and ID: command wins, ID handled next cycle
        send_id(8'h40);
        chk("pre_reload_pass", pass_cnt, 1);
        cmd_dest = 6'h09; cmd_vld = 1'b1; ID = 8'hC9; ID_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        chk("reload_go", go, 1);
        chk("reload_pass_clr", pass_cnt, 0);
        chk("reload_clr_low", clr_ID_vld, 0);
        step();
        chk("reload_check_clr", clr_ID_vld, 1);
        chk("reload_station", station, 9);
        step();
        ID_vld = 1'b0;
        chk("reload_arrive", arrived, 1);
        chk("reload_arr_go", go, 0);
        step();

        // Reset asserted while in CHECK
        start(6'h04);
        send_id(8'h01);
        ID = 8'h04; ID_vld = 1'b1;
        step();
        chk("pre_rst_check", clr_ID_vld, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; ID_vld = 1'b0; #1;
        chk("midrst_go", go, 0);
        chk("midrst_arrived", arrived, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_station", station, 0);
        chk("midrst_pass", pass_cnt, 0);
        chk("midrst_clr", clr_ID_vld, 0);

        // Randomized trips against the counting model
        for (int t = 0; t < 20; t++) begin
            d = 6'($urandom);
            start(d);
            exp_pass = 0;
            chk("rnd_start_pass", pass_cnt, 0);
            nmiss = $urandom_range(0, MAX_MISS);
            for (int m = 0; m < nmiss; m++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) step();
                id = 8'($urandom);
                if (id[5:0] == d) id[5:0] = ~d;
                send_id(id);
                exp_pass = (exp_pass < 15) ? exp_pass + 1 : 15;
                chk("rnd_pass", pass_cnt, exp_pass);
                chk("rnd_go", go, 1);
            end
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            id = 8'($urandom);
            id[5:0] = d;
            send_id(id);
            chk("rnd_arrived", arrived, 1);
            chk("rnd_final_pass", pass_cnt, exp_pass);
            chk("rnd_station", station, d);
            step();
            chk("rnd_idle", busy, 0);
        end

`ifndef STATION_MISS_LIMIT_EN
        // pass_cnt saturates at 15
        start(6'h3F);
        repeat (17) send_id(8'h00);
        chk("sat_pass", pass_cnt, 15);
        send_id(8'hFF);
        chk("sat_arrive", arrived, 1);
        chk("sat_pass_hold", pass_cnt, 15);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
